frame_update_scheduler: RTL and testbench
=========================================

# frame_update_scheduler

Sequences per-frame object updates for the VGA sprite renderer.
- Counts vertical-sync frames and, every FRAME_DIV frames, requests a new bird position from game logic through a req/ack handshake.
- Scrolls the pipe pair leftward, with wrap-around and a new gap height on each wrap.
- Commits all sprite bounding boxes only while VS is low, so the address generator never sees a box change mid-frame.
- Sits between the game/CPU logic and the VGA address generator, and replaces its inline animation counter.

## Interface
Parameters:
- SCREEN_W, 640, screen width in pixels
- SCREEN_H, 480, screen height in lines
- BIRD_X, 320, fixed bird left edge
- BIRD_W, 45, bird width
- BIRD_H, 35, bird height
- PIPE_W, 54, pipe width
- GAP, 50, vertical gap between pipes
- PIPE_X_INIT, 200, reset pipe centre x
- GAP_Y_INIT, 200, reset gap centre y
- PIPE_SPEED, 2, pixels scrolled per update
- FRAME_DIV, 30, frames per update (≥1)

Ports:
- iVGA_CLK  in  1  pixel clock; all logic on rising edge
- iRST_n  in  1  reset; synchronous, active-low
- iVS  in  1  active-low vertical sync from the sync generator
- iEnable  in  1  game running; 0 freezes scheduling
- oPos_req  out  1  position request to game logic
- iPos_ack  in  1  game logic acknowledge; data valid this cycle
- bird_y_long  in  32  signed bird top y, sampled on ack
- iGap_y  in  19  new gap centre, sampled when the pipe wraps
- oUpdate  out  1  one-cycle pulse when new boxes are committed
- oOverrun  out  1  one-cycle pulse when a tick is dropped
- oBird_left/right/top/bottom  out  19 each  bird box
- oLpipe_left/right/top/bottom  out  19 each  lower pipe box
- oUpipe_left/right/top/bottom  out  19 each  upper pipe box

## Operation
- VS fall detect: register iVS as vs_d; fall = vs_d & ~iVS.
- frame_cnt (5+ bits):
  - On fall with iEnable=1: if frame_cnt==FRAME_DIV-1, set it to 0 and raise tick; else increment.
  - iEnable=0: frame_cnt holds at 0.
- FSM states: IDLE, REQ, CALC, WAIT_VS, COMMIT.
  - IDLE: on tick go to REQ.
  - REQ: oPos_req=1. On iPos_ack, capture bird_y_long and go to CALC; oPos_req is 0 from the next cycle.
  - CALC (1 cycle): compute staging values:
    - by = 0 if bird_y_long[31]=1; SCREEN_H-BIRD_H (445) if above that; else bird_y_long[18:0].
    - If pipe_x < PIPE_W/2+PIPE_SPEED (29): pipe_x_n = SCREEN_W-1-PIPE_W/2 (612), and gap_n = iGap_y clamped to [GAP/2+1, SCREEN_H-GAP/2-1] = [26, 454].
    - Otherwise: pipe_x_n = pipe_x-PIPE_SPEED, gap_n = gap.
  - CALC exit: go to COMMIT if iVS==0, else WAIT_VS.
  - WAIT_VS: go to COMMIT on the next fall.
  - COMMIT (1 cycle):
    - Load pipe_x, gap and all outputs; oUpdate=1; return to IDLE.
    - Bird box: left=BIRD_X, right=BIRD_X+BIRD_W, top=by, bottom=by+BIRD_H.
    - Lower pipe: left=pipe_x-PIPE_W/2, right=left+PIPE_W, top=gap+GAP/2, bottom=SCREEN_H.
    - Upper pipe: same left/right; top=0, bottom=gap-GAP/2.
- Overrun: a tick while the FSM is not in IDLE is discarded and oOverrun pulses. frame_cnt still resets.
- iEnable falling mid-transaction does not abort; the FSM completes to IDLE.
- Arithmetic: all coordinates are unsigned 19-bit; divisions are integer (PIPE_W/2=27, GAP/2=25). The clamps above guarantee no underflow.

## Timing
- Reset (iRST_n=0 at a rising edge):
  - FSM=IDLE, frame_cnt=0, vs_d=1; oPos_req, oUpdate and oOverrun are 0.
  - pipe_x=200, gap=200.
  - Bird box = 320/365/0/35.
  - Lower pipe = 173/227/225/480.
  - Upper pipe = 173/227/0/175.
- Reset mid-transaction returns all of the above immediately; a pending request is dropped.
- Tick → oPos_req: 1 cycle (fall at edge N, oPos_req=1 after edge N+1).
- Ack at edge A while VS is low: CALC at A+1, COMMIT at A+2; outputs change and oUpdate=1 after edge A+2.
- Ack arriving on the same cycle oPos_req rises is legal.
- iPos_ack while not in REQ is ignored.
- Outputs never change outside COMMIT.

## Test plan
- Reset: hold iRST_n=0 for 3 cycles → all outputs equal the reset values listed in Timing; oPos_req=0.
- FRAME_DIV=3, iEnable=1, ack 2 cycles after req, bird_y_long=100 during VS low → oPos_req on the 3rd VS fall only; bird box becomes 320/365/100/135; lower-pipe left becomes 171; exactly one oUpdate.
- bird_y_long=-5 then 470 → top=0/bottom=35, then top=445/bottom=480.
- pipe_x forced by repeated updates to 28 with iGap_y=10 → pipe_x=612, gap=26; upper bottom=1, lower top=51; pipe left=585, right=639.
- Ack delayed until VS high → no output change until the next VS fall, then oUpdate. A further tick during the wait → oOverrun pulse; only one commit occurs.
- iEnable=0 for 10 frames → no oPos_req and frame_cnt stays 0. Apply iRST_n=0 while in REQ → oPos_req drops after that edge; boxes return to reset values.

Source files
------------

// File: rtl/frame_update_scheduler.sv
// Per-frame sprite update sequencer: requests a bird position every FRAME_DIV frames,
// scrolls the pipe pair and commits all bounding boxes only while vertical sync is low.
module frame_update_scheduler #(
    parameter int unsigned SCREEN_W    = 640,
    parameter int unsigned SCREEN_H    = 480,
    parameter int unsigned BIRD_X      = 320,
    parameter int unsigned BIRD_W      = 45,
    parameter int unsigned BIRD_H      = 35,
    parameter int unsigned PIPE_W      = 54,
    parameter int unsigned GAP         = 50,
    parameter int unsigned PIPE_X_INIT = 200,
    parameter int unsigned GAP_Y_INIT  = 200,
    parameter int unsigned PIPE_SPEED  = 2,
    parameter int unsigned FRAME_DIV   = 30
) (
    input  logic        iVGA_CLK,
    input  logic        iRST_n,
    input  logic        iVS,
    input  logic        iEnable,
    output logic        oPos_req,
    input  logic        iPos_ack,
    input  logic [31:0] bird_y_long,
    input  logic [18:0] iGap_y,
    output logic        oUpdate,
    output logic        oOverrun,
    output logic [18:0] oBird_left,
    output logic [18:0] oBird_right,
    output logic [18:0] oBird_top,
    output logic [18:0] oBird_bottom,
    output logic [18:0] oLpipe_left,
    output logic [18:0] oLpipe_right,
    output logic [18:0] oLpipe_top,
    output logic [18:0] oLpipe_bottom,
    output logic [18:0] oUpipe_left,
    output logic [18:0] oUpipe_right,
    output logic [18:0] oUpipe_top,
    output logic [18:0] oUpipe_bottom
);

    localparam int unsigned CW  = 19;
    localparam int unsigned FDW = ($clog2(FRAME_DIV) > 5) ? $clog2(FRAME_DIV) : 5;

    localparam logic [FDW-1:0] FD_LAST     = FDW'(FRAME_DIV - 1);
    localparam logic [CW-1:0]  BY_MAX      = CW'(SCREEN_H - BIRD_H);
    localparam logic [CW-1:0]  WRAP_LIM    = CW'(PIPE_W / 2 + PIPE_SPEED);
    localparam logic [CW-1:0]  PIPE_X_WRAP = CW'(SCREEN_W - 1 - PIPE_W / 2);
    localparam logic [CW-1:0]  GAP_LO      = CW'(GAP / 2 + 1);
    localparam logic [CW-1:0]  GAP_HI      = CW'(SCREEN_H - GAP / 2 - 1);
    localparam logic [CW-1:0]  HALF_PW     = CW'(PIPE_W / 2);
    localparam logic [CW-1:0]  HALF_GAP    = CW'(GAP / 2);
    localparam logic [CW-1:0]  PW_C        = CW'(PIPE_W);
    localparam logic [CW-1:0]  BH_C        = CW'(BIRD_H);
    localparam logic [CW-1:0]  SPEED_C     = CW'(PIPE_SPEED);
    localparam logic [CW-1:0]  RST_PX      = CW'(PIPE_X_INIT);
    localparam logic [CW-1:0]  RST_GAP     = CW'(GAP_Y_INIT);
    localparam logic [CW-1:0]  RST_PLEFT   = CW'(PIPE_X_INIT - PIPE_W / 2);
    localparam logic [CW-1:0]  RST_PRIGHT  = CW'(PIPE_X_INIT - PIPE_W / 2 + PIPE_W);
    localparam logic [CW-1:0]  RST_LTOP    = CW'(GAP_Y_INIT + GAP / 2);
    localparam logic [CW-1:0]  RST_UBOT    = CW'(GAP_Y_INIT - GAP / 2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_CALC,
        S_WAIT_VS,
        S_COMMIT
    } state_e;

    state_e          state_q, state_d;
    logic            vs_q, vs_d;
    logic            fall_c;
    logic [FDW-1:0]  frame_cnt_q, frame_cnt_d;
    logic            tick_q, tick_d;
    logic            req_q, req_d;
    logic            update_q, update_d;
    logic            overrun_q, overrun_d;
    logic [31:0]     bird_y_q, bird_y_d;
    logic [CW-1:0]   by_q, by_d;
    logic [CW-1:0]   by_clamp_c, gap_clamp_c;
    logic [CW-1:0]   pipe_x_n_q, pipe_x_n_d;
    logic [CW-1:0]   gap_n_q, gap_n_d;
    logic [CW-1:0]   pipe_x_q, pipe_x_d;
    logic [CW-1:0]   gap_q, gap_d;
    logic [CW-1:0]   bird_top_q, bird_top_d;
    logic [CW-1:0]   bird_bot_q, bird_bot_d;
    logic [CW-1:0]   pipe_left_q, pipe_left_d;
    logic [CW-1:0]   pipe_right_q, pipe_right_d;
    logic [CW-1:0]   lp_top_q, lp_top_d;
    logic [CW-1:0]   up_bot_q, up_bot_d;

    // Frame divider, handshake sequencing and box staging
    always_comb begin
        state_d      = state_q;
        vs_d         = iVS;
        fall_c       = vs_q & ~iVS;
        frame_cnt_d  = frame_cnt_q;
        tick_d       = 1'b0;
        bird_y_d     = bird_y_q;
        by_d         = by_q;
        pipe_x_n_d   = pipe_x_n_q;
        gap_n_d      = gap_n_q;
        pipe_x_d     = pipe_x_q;
        gap_d        = gap_q;
        bird_top_d   = bird_top_q;
        bird_bot_d   = bird_bot_q;
        pipe_left_d  = pipe_left_q;
        pipe_right_d = pipe_right_q;
        lp_top_d     = lp_top_q;
        up_bot_d     = up_bot_q;
        update_d     = 1'b0;
        overrun_d    = tick_q && (state_q != S_IDLE);

        if (bird_y_q[31]) begin
            by_clamp_c = '0;
        end else if (bird_y_q > 32'(SCREEN_H - BIRD_H)) begin
            by_clamp_c = BY_MAX;
        end else begin
            by_clamp_c = bird_y_q[CW-1:0];
        end

        if (iGap_y < GAP_LO) begin
            gap_clamp_c = GAP_LO;
        end else if (iGap_y > GAP_HI) begin
            gap_clamp_c = GAP_HI;
        end else begin
            gap_clamp_c = iGap_y;
        end

        if (!iEnable) begin
            frame_cnt_d = '0;
        end else if (fall_c) begin
            if (frame_cnt_q == FD_LAST) begin
                frame_cnt_d = '0;
                tick_d      = 1'b1;
            end else begin
                frame_cnt_d = frame_cnt_q + 1'b1;
            end
        end

        case (state_q)
            S_IDLE: begin
                if (tick_q) state_d = S_REQ;
            end
            S_REQ: begin
                if (iPos_ack) begin
                    bird_y_d = bird_y_long;
                    state_d  = S_CALC;
                end
            end
            S_CALC: begin
                by_d = by_clamp_c;
                if (pipe_x_q < WRAP_LIM) begin
                    pipe_x_n_d = PIPE_X_WRAP;
                    gap_n_d    = gap_clamp_c;
                end else begin
                    pipe_x_n_d = pipe_x_q - SPEED_C;
                    gap_n_d    = gap_q;
                end
                state_d = iVS ? S_WAIT_VS : S_COMMIT;
            end
            S_WAIT_VS: begin
                if (fall_c) state_d = S_COMMIT;
            end
            S_COMMIT: begin
                pipe_x_d     = pipe_x_n_q;
                gap_d        = gap_n_q;
                bird_top_d   = by_q;
                bird_bot_d   = by_q + BH_C;
                pipe_left_d  = pipe_x_n_q - HALF_PW;
                pipe_right_d = pipe_x_n_q - HALF_PW + PW_C;
                lp_top_d     = gap_n_q + HALF_GAP;
                up_bot_d     = gap_n_q - HALF_GAP;
                update_d     = 1'b1;
                state_d      = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        req_d = (state_d == S_REQ);
    end

    always_ff @(posedge iVGA_CLK) begin
        if (!iRST_n) begin
            state_q      <= S_IDLE;
            vs_q         <= 1'b1;
            frame_cnt_q  <= '0;
            tick_q       <= 1'b0;
            req_q        <= 1'b0;
            update_q     <= 1'b0;
            overrun_q    <= 1'b0;
            bird_y_q     <= '0;
            by_q         <= '0;
            pipe_x_n_q   <= RST_PX;
            gap_n_q      <= RST_GAP;
            pipe_x_q     <= RST_PX;
            gap_q        <= RST_GAP;
            bird_top_q   <= '0;
            bird_bot_q   <= BH_C;
            pipe_left_q  <= RST_PLEFT;
            pipe_right_q <= RST_PRIGHT;
            lp_top_q     <= RST_LTOP;
            up_bot_q     <= RST_UBOT;
        end else begin
            state_q      <= state_d;
            vs_q         <= vs_d;
            frame_cnt_q  <= frame_cnt_d;
            tick_q       <= tick_d;
            req_q        <= req_d;
            update_q     <= update_d;
            overrun_q    <= overrun_d;
            bird_y_q     <= bird_y_d;
            by_q         <= by_d;
            pipe_x_n_q   <= pipe_x_n_d;
            gap_n_q      <= gap_n_d;
            pipe_x_q     <= pipe_x_d;
            gap_q        <= gap_d;
            bird_top_q   <= bird_top_d;
            bird_bot_q   <= bird_bot_d;
            pipe_left_q  <= pipe_left_d;
            pipe_right_q <= pipe_right_d;
            lp_top_q     <= lp_top_d;
            up_bot_q     <= up_bot_d;
        end
    end

    // Fixed edges are constants; the rest come straight from registers
    assign oPos_req      = req_q;
    assign oUpdate       = update_q;
    assign oOverrun      = overrun_q;
    assign oBird_left    = CW'(BIRD_X);
    assign oBird_right   = CW'(BIRD_X + BIRD_W);
    assign oBird_top     = bird_top_q;
    assign oBird_bottom  = bird_bot_q;
    assign oLpipe_left   = pipe_left_q;
    assign oLpipe_right  = pipe_right_q;
    assign oLpipe_top    = lp_top_q;
    assign oLpipe_bottom = CW'(SCREEN_H);
    assign oUpipe_left   = pipe_left_q;
    assign oUpipe_right  = pipe_right_q;
    assign oUpipe_top    = '0;
    assign oUpipe_bottom = up_bot_q;

endmodule

// File: tb/tb_frame_update_scheduler.sv
// Bench for frame_update_scheduler: random VS/ack/enable traffic against a transaction-level model.
module tb_frame_update_scheduler;

    localparam int FDIV = 3;

    logic        clk;
    logic        rst_n;
    logic        vs;
    logic        en;
    logic        ack;
    logic [31:0] bird_y;
    logic [18:0] gap_y;
    logic        req_o, upd_o, ovr_o;
    logic [18:0] bl, br, bt, bb, ll, lr, lt, lb, ul, ur, ut, ub;

    frame_update_scheduler #(.FRAME_DIV(FDIV)) dut (
        .iVGA_CLK(clk), .iRST_n(rst_n), .iVS(vs), .iEnable(en),
        .oPos_req(req_o), .iPos_ack(ack), .bird_y_long(bird_y), .iGap_y(gap_y),
        .oUpdate(upd_o), .oOverrun(ovr_o),
        .oBird_left(bl), .oBird_right(br), .oBird_top(bt), .oBird_bottom(bb),
        .oLpipe_left(ll), .oLpipe_right(lr), .oLpipe_top(lt), .oLpipe_bottom(lb),
        .oUpipe_left(ul), .oUpipe_right(ur), .oUpipe_top(ut), .oUpipe_bottom(ub)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Configuration written only by the main process
    int en_cfg, resp_mode, ack_delay, dir_bird, ack_odds;

    // VS generator: short frames, VS low for a few lines; enable policy per frame
    initial begin
        bit en_frame;
        vs = 1'b1;
        en = 1'b0;
        en_frame = 1'b1;
        forever begin
            int lo_n, hi_n;
            lo_n = $urandom_range(3, 6);
            hi_n = $urandom_range(14, 18);
            en_frame = ($urandom_range(0, 99) < 85);
            for (int i = 0; i < lo_n + hi_n; i++) begin
                @(posedge clk);
                #1;
                vs = (i >= lo_n);
                en = (en_cfg == 1) || (en_cfg == 2 && en_frame);
            end
        end
    end

    function automatic int rand_bird();
        case ($urandom_range(0, 6))
            0: return -5;
            1: return 470;
            2: return 445;
            3: return 446;
            4: return 0;
            5: return -int'($urandom_range(1, 100000));
            default: return int'($urandom_range(0, 500));
        endcase
    endfunction

    // Game-logic responder
    initial begin
        int age;
        ack = 1'b0;
        bird_y = '0;
        age = 0;
        forever begin
            @(posedge clk);
            #1;
            if (req_o) age++;
            else age = 0;
            case (resp_mode)
                0: ack = 1'b0;
                1: begin
                    ack = (age == ack_delay);
                    bird_y = 32'(dir_bird);
                end
                default: begin
                    ack = ($urandom_range(0, ack_odds - 1) == 0);
                    bird_y = 32'(rand_bird());
                end
            endcase
        end
    end

    // Transaction-level reference: expected state after each rising edge
    int m_e, m_frames, m_calc_e, m_commit_e, m_bird, m_by, m_px, m_gap, m_px_n, m_gap_n, m_top;
    bit m_valid, m_vs_prev, m_tick, m_busy, m_req, m_wait, m_upd, m_ovr;

    function automatic int clamp(input int v, input int lo, input int hi);
        if (v < lo) return lo;
        if (v > hi) return hi;
        return v;
    endfunction

    initial begin
        m_valid = 1'b0;
        m_e = 0;
    end

    always @(posedge clk) begin
        bit fall, tick_now, was_busy;
        m_e++;
        if (!rst_n) begin
            m_valid = 1'b1; m_vs_prev = 1'b1; m_frames = 0; m_tick = 1'b0;
            m_busy = 1'b0; m_req = 1'b0; m_wait = 1'b0; m_upd = 1'b0; m_ovr = 1'b0;
            m_px = 200; m_gap = 200; m_top = 0; m_calc_e = -1; m_commit_e = -1;
        end else begin
            fall = m_vs_prev && !vs;
            m_vs_prev = vs;
            tick_now = 1'b0;
            if (!en) m_frames = 0;
            else if (fall) begin
                m_frames++;
                if (m_frames == FDIV) begin
                    m_frames = 0;
                    tick_now = 1'b1;
                end
            end
            m_upd = 1'b0;
            m_ovr = 1'b0;
            was_busy = m_busy;
            if (m_busy) begin
                if (m_commit_e == m_e) begin
                    m_px = m_px_n; m_gap = m_gap_n; m_top = m_by;
                    m_busy = 1'b0; m_upd = 1'b1;
                end else if (m_wait) begin
                    if (fall) begin
                        m_commit_e = m_e + 1;
                        m_wait = 1'b0;
                    end
                end else if (m_calc_e == m_e) begin
                    m_by = clamp(m_bird, 0, 445);
                    if (m_px < 29) begin
                        m_px_n = 612;
                        m_gap_n = clamp(int'(gap_y), 26, 454);
                    end else begin
                        m_px_n = m_px - 2;
                        m_gap_n = m_gap;
                    end
                    if (!vs) m_commit_e = m_e + 1;
                    else m_wait = 1'b1;
                end else if (m_req && ack) begin
                    m_bird = int'($signed(bird_y));
                    m_req = 1'b0;
                    m_calc_e = m_e + 1;
                end
            end
            if (m_tick) begin
                if (was_busy) m_ovr = 1'b1;
                else begin
                    m_busy = 1'b1; m_req = 1'b1; m_wait = 1'b0;
                    m_calc_e = -1; m_commit_e = -1;
                end
            end
            m_tick = tick_now;
        end
    end

    int pass_cnt, tot_cnt, upd_cnt, ovr_cnt, req_rise, falls, falls_at_req;
    bit req_prev, vs_prev_s, req_seen;

    task automatic compare_cycle();
        logic [230:0] act, expv;
        if (m_valid) begin
            act  = {req_o, upd_o, ovr_o, bl, br, bt, bb, ll, lr, lt, lb, ul, ur, ut, ub};
            expv = {m_req, m_upd, m_ovr, 19'(320), 19'(365), 19'(m_top), 19'(m_top + 35),
                    19'(m_px - 27), 19'(m_px + 27), 19'(m_gap + 25), 19'(480),
                    19'(m_px - 27), 19'(m_px + 27), 19'(0), 19'(m_gap - 25)};
            tot_cnt++;
            if (act === expv) pass_cnt++;
            else $display("FAIL cycle @%0t: got %h expected %h", $time, act, expv);
        end
        if (upd_o) upd_cnt++;
        if (ovr_o) ovr_cnt++;
        if (req_o && !req_prev) begin
            req_rise++;
            if (!req_seen) begin
                req_seen = 1'b1;
                falls_at_req = falls;
            end
        end
        req_prev = req_o;
        if (vs_prev_s && !vs) falls++;
        vs_prev_s = vs;
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            compare_cycle();
        end
    endtask

    task automatic chk(input string nm, input int act, input int exp_v);
        tot_cnt++;
        if (act == exp_v) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp_v);
    endtask

    task automatic chk_boxes(input string nm, input int top, input int pl, input int ltop, input int ubot);
        chk({nm, ".bird_l"}, int'(bl), 320);
        chk({nm, ".bird_r"}, int'(br), 365);
        chk({nm, ".bird_t"}, int'(bt), top);
        chk({nm, ".bird_b"}, int'(bb), top + 35);
        chk({nm, ".lp_l"}, int'(ll), pl);
        chk({nm, ".lp_r"}, int'(lr), pl + 54);
        chk({nm, ".lp_t"}, int'(lt), ltop);
        chk({nm, ".lp_b"}, int'(lb), 480);
        chk({nm, ".up_l"}, int'(ul), pl);
        chk({nm, ".up_r"}, int'(ur), pl + 54);
        chk({nm, ".up_t"}, int'(ut), 0);
        chk({nm, ".up_b"}, int'(ub), ubot);
    endtask

    task automatic wait_upd(input string nm, input int budget);
        int start;
        start = upd_cnt;
        for (int i = 0; i < budget && upd_cnt == start; i++) step(1);
        if (upd_cnt == start) chk({nm, ".timeout"}, 0, 1);
    endtask

    initial begin
        int o0, r0;
        bit found;
        pass_cnt = 0; tot_cnt = 0; upd_cnt = 0; ovr_cnt = 0; req_rise = 0;
        falls = 0; falls_at_req = -1; req_prev = 1'b0; vs_prev_s = 1'b1; req_seen = 1'b0;
        rst_n = 1'b0; gap_y = 19'd10;
        en_cfg = 0; resp_mode = 0; ack_delay = 2; dir_bird = 100; ack_odds = 8;

        step(3);
        chk_boxes("reset", 0, 173, 225, 175);
        chk("reset.req", int'(req_o), 0);
        chk("reset.upd", int'(upd_o), 0);
        chk("reset.ovr", int'(ovr_o), 0);

        rst_n = 1'b1; en_cfg = 1; resp_mode = 1; falls = 0;
        wait_upd("first", 400);
        chk("falls_before_req", falls_at_req, 3);
        chk_boxes("upd1", 100, 171, 225, 175);
        chk("upd1.no_overrun", ovr_cnt, 0);

        dir_bird = -5;
        wait_upd("neg_bird", 400);
        chk("neg.top", int'(bt), 0);
        chk("neg.bottom", int'(bb), 35);
        chk("neg.lp_l", int'(ll), 169);

        dir_bird = 470;
        wait_upd("big_bird", 400);
        chk("big.top", int'(bt), 445);
        chk("big.bottom", int'(bb), 480);

        dir_bird = 300; ack_delay = 10;
        wait_upd("late_ack", 400);
        chk("late.top", int'(bt), 300);

        dir_bird = 200; ack_delay = 100; o0 = ovr_cnt;
        wait_upd("overrun", 600);
        chk("overrun.seen", int'(ovr_cnt > o0), 1);
        chk("overrun.top", int'(bt), 200);

        ack_delay = 2; en_cfg = 0; r0 = req_rise;
        step(240);
        chk("disabled.no_req", req_rise - r0, 0);

        en_cfg = 2; resp_mode = 2; ack_odds = 8;
        found = 1'b0;
        for (int i = 0; i < 30000 && !found; i++) begin
            step(1);
            found = (ll == 19'd585);
        end
        chk("wrap.reached", int'(found), 1);
        chk("wrap.lp_r", int'(lr), 639);
        chk("wrap.lp_t", int'(lt), 51);
        chk("wrap.up_b", int'(ub), 1);

        ack_odds = 40;
        for (int i = 0; i < 1500; i++) begin
            step(1);
            gap_y = 19'($urandom_range(0, 600));
        end

        resp_mode = 0; en_cfg = 1;
        found = 1'b0;
        for (int i = 0; i < 400 && !found; i++) begin
            step(1);
            found = req_o;
        end
        chk("reqwait.seen", int'(found), 1);
        rst_n = 1'b0;
        step(1);
        chk("rst_in_req.req", int'(req_o), 0);
        chk_boxes("rst_in_req", 0, 173, 225, 175);
        rst_n = 1'b1; resp_mode = 1; dir_bird = 100;
        wait_upd("post_reset", 400);
        chk("post_reset.top", int'(bt), 100);
        chk("post_reset.lp_l", int'(ll), 171);
        step(20);

        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end

endmodule
